window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Upstream feeder for the 9-input median sorter.
- Accepts a raster-order 8-bit grayscale pixel stream, one pixel per cycle maximum, and buffers two previous image rows.
- Emits a 3x3 neighbourhood (px0..px8) plus a valid strobe for every interior pixel, so the sorter downstream takes one window per clock.

Parameters:
- IMG_WIDTH, 640, pixels per row (>= 3)
- IMG_HEIGHT, 480, rows per frame (>= 3)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel on in_pix is accepted this cycle
- in_sof  in  1  qualifies with in_valid: this pixel is (row 0, col 0) of a new frame
- in_pix  in  PIX_W  input pixel
- win_valid  out  1  px0..px8 hold a complete window; one-cycle strobe
- px0..px8  out  PIX_W each  window; px0=(r-2,c-2), px1=(r-2,c-1), px2=(r-2,c), px3=(r-1,c-2) ... px8=(r,c), row-major
- win_row  out  clog2(IMG_HEIGHT)  row of window centre (r-1)
- win_col  out  clog2(IMG_WIDTH)  column of window centre (c-1)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst_n low, async): col/row counters=0; win_valid=0; frame_done=0; px0..px8=0; win_row=win_col=0. Line-buffer contents need not be cleared; validity gating makes them don't-care.
- Counters: col increments on each accepted pixel. At IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- in_sof with in_valid: the pixel is treated as (0,0) regardless of counter state, so frames resync mid-stream. in_sof without in_valid is ignored.
- Line buffers: two buffers of depth IMG_WIDTH, chained.
  - LB0 holds row r-1; LB1 holds row r-2.
  - On an accepted pixel at column c: read LB0[c] and LB1[c] combinationally (old data), write LB1[c]<=LB0[c] and LB0[c]<=in_pix in the same cycle.
- Window: 3 rows x 3 columns of registers.
  - On an accepted pixel, each row shifts left one column.
  - The new right column is {LB1[c], LB0[c], in_pix}.
- Output latency: exactly 1 cycle. An accepted pixel at (r,c) sets win_valid in the next cycle iff r>=2 and c>=2, with win_row=r-1 and win_col=c-1.
  - Edge rows and columns produce no window; the downstream border policy is not this block's concern.
- No accept cycle (in_valid=0): window, counters and px outputs hold; win_valid=0 next cycle.
- Windows never mix columns across a row boundary or rows across frames. This is guaranteed by the c>=2 / r>=2 gating, which uses counter values after any in_sof resync.
- frame_done=1 in the cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, coincident with that pixel's win_valid.
- No backpressure: the sorter is fully pipelined, so the block is always ready.
- Reset mid-frame: all state returns to reset values. The next accepted pixel counts as (0,0) even without in_sof.
- Outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package (pixel_pkg): PIX_W localparam, pixel_t typedef (logic [PIX_W-1:0]), window_t typedef (array [0:8] of pixel_t).
- Sub-module line_buffer: single IMG_WIDTH-deep PIX_W memory with combinational read, synchronous write at a shared address, and write enable. Instantiate twice.
- Counters, window registers and output logic live in window_3x3_gen.

Test Plan:
1. Ramp frame, IMG_WIDTH=4, IMG_HEIGHT=4, pixel value=4r+c, in_valid continuous, in_sof on the first pixel:
   - exactly 4 win_valid strobes;
   - first window, one cycle after pixel 10: px0..px8=0,1,2,4,5,6,8,9,10, win_row=1, win_col=1;
   - last window: 5,6,7,9,10,11,13,14,15, win_row=2, win_col=2;
   - frame_done pulses with the last strobe.
2. Same frame with in_valid dropped for 1-3 random cycles between pixels: identical windows in identical order; win_valid never high in a cycle following a non-accept cycle.
3. Back-to-back frames, second frame values = 100+4r+c: no strobe until second-frame pixel (2,2); first window 100,101,102,104,105,106,108,109,110.
4. in_sof asserted at pixel (1,3) of the first frame, then a full fresh frame follows: counters resync and output matches scenario 1 relative to the sof pixel; no window contains pre-sof data.
5. rst_n pulsed low asynchronously mid-frame at pixel (2,3): all outputs 0 immediately; the following frame (no in_sof) produces the scenario 1 results.
6. Constant-255 image with one 0 pixel at (2,2): the 4 windows centred on (1,1),(1,2),(2,1),(2,2) each contain exactly one 0, at px8, px7, px5, px4 respectively.

Source files
------------

// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
// Shared pixel types for the 3x3 window generator and its neighbours in the
// median-filter pipeline.
//   PIX_W    : default pixel width in bits
//   pixel_t  : one grayscale pixel
//   window_t : a 3x3 neighbourhood, row-major, index 0 = top-left
// ---------------------------------------------------------------------------
package pixel_pkg;

   localparam int PIX_W = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef pixel_t window_t [0:8];

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image row of pixel storage. Reads are combinational, so the caller
// sees the old contents of a location in the same cycle it overwrites it.
// The memory has no reset because the window logic never emits a window
// that depends on a location it has not written yet.
// Ports:
//   clk     : rising-edge clock
//   we      : write enable
//   addr    : shared read/write address (column)
//   wr_data : data written at addr when we is high
//   rd_data : current contents at addr
// ---------------------------------------------------------------------------
module line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/window_3x3_gen.sv
// ---------------------------------------------------------------------------
// window_3x3_gen
// Turns a raster-order pixel stream into 3x3 neighbourhoods for a downstream
// median sorter. Two chained line buffers hold the previous two rows; a 3x3
// register array shifts left on each accepted pixel. A window is emitted one
// cycle after every pixel whose row and column are both >= 2.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid      : pixel accepted this cycle (always ready)
//   in_sof        : with in_valid, forces this pixel to be (0,0)
//   in_pix        : input pixel
//   win_valid     : one-cycle strobe, px0..px8 hold a full window
//   px0..px8      : window, row-major, px8 = newest pixel
//   win_row/col   : coordinates of the window centre
//   frame_done    : pulses with the window of the last pixel of a frame
// ---------------------------------------------------------------------------
module window_3x3_gen
   import pixel_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_W      = pixel_pkg::PIX_W,
   localparam int CW        = $clog2(IMG_WIDTH),
   localparam int RW        = $clog2(IMG_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pix,
   output logic             win_valid,
   output logic [PIX_W-1:0] px0,
   output logic [PIX_W-1:0] px1,
   output logic [PIX_W-1:0] px2,
   output logic [PIX_W-1:0] px3,
   output logic [PIX_W-1:0] px4,
   output logic [PIX_W-1:0] px5,
   output logic [PIX_W-1:0] px6,
   output logic [PIX_W-1:0] px7,
   output logic [PIX_W-1:0] px8,
   output logic [RW-1:0]    win_row,
   output logic [CW-1:0]    win_col,
   output logic             frame_done
);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [CW-1:0]    cur_col;
   logic [RW-1:0]    cur_row;
   logic [PIX_W-1:0] lb0_rd;
   logic [PIX_W-1:0] lb1_rd;
   logic [PIX_W-1:0] win [0:8];
   logic             emit;
   logic             last_pix;

   // A start-of-frame pixel overrides whatever the counters say, so all
   // addressing and gating below uses the resynced coordinates.
   always_comb begin
      cur_col  = col;
      cur_row  = row;
      if (in_sof) begin
         cur_col = '0;
         cur_row = '0;
      end
      emit     = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      last_pix = in_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
   end

   // LB0 holds row r-1 and LB1 row r-2; on each accept the old LB0 entry
   // moves down into LB1 while the new pixel replaces it in LB0.
   line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
      .clk     (clk),
      .we      (in_valid),
      .addr    (cur_col),
      .wr_data (in_pix),
      .rd_data (lb0_rd)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
      .clk     (clk),
      .we      (in_valid),
      .addr    (cur_col),
      .wr_data (lb0_rd),
      .rd_data (lb1_rd)
   );

   // Raster counters: column wraps into the row, row wraps at frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
         end else begin
            col <= cur_col + CW'(1);
            row <= cur_row;
         end
      end
   end

   // Window shift register plus registered strobes. Coordinates only move
   // when a window is emitted so they always describe the last window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) begin
            win[i] <= '0;
         end
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
      end else begin
         win_valid  <= emit;
         frame_done <= last_pix;
         if (in_valid) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1_rd;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0_rd;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_pix;
         end
         if (emit) begin
            win_row <= cur_row - RW'(1);
            win_col <= cur_col - CW'(1);
         end
      end
   end

   assign px0 = win[0];
   assign px1 = win[1];
   assign px2 = win[2];
   assign px3 = win[3];
   assign px4 = win[4];
   assign px5 = win[5];
   assign px6 = win[6];
   assign px7 = win[7];
   assign px8 = win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// ---------------------------------------------------------------------------
// tb_window_3x3_gen
// Scoreboard bench for window_3x3_gen on a 4x4 image. The driver pushes the
// window it expects for every interior pixel; a monitor pops and compares
// whenever win_valid is seen.
// ---------------------------------------------------------------------------
module tb_window_3x3_gen;

   localparam int W = 4;
   localparam int H = 4;

   typedef struct packed {
      logic [8:0][7:0] px;
      logic [1:0]      row;
      logic [1:0]      col;
      logic            fd;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_pix;
   logic       win_valid;
   logic [7:0] px0, px1, px2, px3, px4, px5, px6, px7, px8;
   logic [1:0] win_row;
   logic [1:0] win_col;
   logic       frame_done;

   int         vectors;
   int         miscompares;
   int         strobeCount;
   logic       prevAccept;
   exp_t       q[$];
   logic [7:0] img [0:H-1][0:W-1];

   window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_pix     (in_pix),
      .win_valid  (win_valid),
      .px0        (px0),
      .px1        (px1),
      .px2        (px2),
      .px3        (px3),
      .px4        (px4),
      .px5        (px5),
      .px6        (px6),
      .px7        (px7),
      .px8        (px8),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Remember whether the previous edge accepted a pixel.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) prevAccept <= 1'b0;
      else        prevAccept <= in_valid;
   end

   // Monitor: compare every presented window against the scoreboard head.
   always @(negedge clk) begin
      exp_t act;
      exp_t exp;
      if (win_valid) begin
         strobeCount++;
         act.px  = {px8, px7, px6, px5, px4, px3, px2, px1, px0};
         act.row = win_row;
         act.col = win_col;
         act.fd  = frame_done;
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL window: unexpected strobe actual px=%h row=%0d col=%0d, required no strobe",
                     act.px, act.row, act.col);
         end else begin
            exp = q.pop_front();
            if (act !== exp) begin
               miscompares++;
               $display("[TB] FAIL window: actual px=%h row=%0d col=%0d fd=%0b, required px=%h row=%0d col=%0d fd=%0b",
                        act.px, act.row, act.col, act.fd, exp.px, exp.row, exp.col, exp.fd);
            end
         end
         vectors++;
         if (!prevAccept) begin
            miscompares++;
            $display("[TB] FAIL strobe_after_idle: actual win_valid=1, required 0");
         end
      end else if (frame_done) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL frame_done_alone: actual frame_done=1 with win_valid=0, required 0");
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_win_valid"}, int'(win_valid), 0);
      checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
      checkOutput({tag, "_px"}, int'(|{px0, px1, px2, px3, px4, px5, px6, px7, px8}), 0);
      checkOutput({tag, "_win_row"}, int'(win_row), 0);
      checkOutput({tag, "_win_col"}, int'(win_col), 0);
   endtask

   task automatic fillRamp(input int base);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'(base + 4 * r + c);
   endtask

   // Drive the first n pixels of img in raster order; optional idle gaps.
   task automatic applyStimulus(input int n, input bit sofFirst, input bit gaps);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         int r;
         int c;
         r = k / W;
         c = k % W;
         in_valid = 1'b1;
         in_sof   = sofFirst && (k == 0);
         in_pix   = img[r][c];
         if (r >= 2 && c >= 2) begin
            for (int j = 0; j < 9; j++)
               e.px[j] = img[r - 2 + j / 3][c - 2 + j % 3];
            e.row = 2'(r - 1);
            e.col = 2'(c - 1);
            e.fd  = (r == H - 1) && (c == W - 1);
            q.push_back(e);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_sof   = 1'b0;
         in_pix   = 8'hxx;
         if (gaps) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic flushCheck(input string tag, input int strobes);
      repeat (3) @(posedge clk);
      #1;
      checkOutput({tag, "_pending"}, q.size(), 0);
      checkOutput({tag, "_strobes"}, strobeCount, strobes);
      q.delete();
      strobeCount = 0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      strobeCount = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_sof      = 1'b0;
      in_pix      = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: ramp frame, continuous
      fillRamp(0);
      applyStimulus(16, 1'b1, 1'b0);
      flushCheck("ramp", 4);

      // 2: same frame with idle gaps
      applyStimulus(16, 1'b1, 1'b1);
      flushCheck("gaps", 4);

      // 3: back-to-back frames
      applyStimulus(16, 1'b1, 1'b0);
      fillRamp(100);
      applyStimulus(16, 1'b1, 1'b0);
      flushCheck("b2b", 8);

      // 4: sof resync at (1,3) with distinctive pre-sof data
      fillRamp(200);
      applyStimulus(7, 1'b1, 1'b0);
      fillRamp(0);
      applyStimulus(16, 1'b1, 1'b0);
      flushCheck("resync", 4);

      // 5: async reset after pixel (2,3), then a frame without sof
      applyStimulus(12, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      flushCheck("prereset", 2);
      applyStimulus(16, 1'b0, 1'b0);
      flushCheck("postreset", 4);

      // 6: constant 255 with a single 0 at (2,2)
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'd255;
      img[2][2] = 8'd0;
      applyStimulus(16, 1'b1, 1'b0);
      flushCheck("hole", 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
